// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and the round-robin search helper for the UART arbiter front end.
// Revision: 1.0
`default_nettype none

package uart_arb_pkg;

  localparam int MAX_CH = 16;
  localparam int CH_W   = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HELD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } arb_pick_t;

  // First set bit of req scanning upward from start, wrapping within n channels.
  function automatic arb_pick_t next_requester(input logic [MAX_CH-1:0] req,
                                               input logic [CH_W-1:0]   start,
                                               input int                n);
    arb_pick_t       pick;
    logic [CH_W:0]   pos;
    pick = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      pos = {1'b0, start} + (CH_W+1)'(k);
      if (pos >= (CH_W+1)'(n)) pos = pos - (CH_W+1)'(n);
      if (k < n && !pick.found && req[pos[CH_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = pos[CH_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo.sv
// fifo: single-clock FIFO with first-word-fall-through read data and an occupancy count.
// Revision: 1.1
`default_nettype none

module fifo #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign do_pop    = rd_en_i & ~empty_o;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign do_push   = wr_en_i & (~full_o | do_pop);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart.sv
// uart: 8N1 transmitter/receiver with cts gating of transmit and rts driven from local_ready.
// Revision: 1.0
`default_nettype none

module uart #(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_FREQ = 125_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in_i,
  input  logic       data_in_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] data_out_o,
  output logic       data_out_valid_o,
  input  logic       local_ready_i,
  input  logic       cts_i,
  output logic       rts_o,
  input  logic       serial_in_i,
  output logic       serial_out_o
);

  localparam int CPB   = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(CPB + 1);

  logic             tx_busy_q;
  logic [9:0]       tx_shift_q;
  logic [3:0]       tx_bit_q;
  logic [CNT_W-1:0] tx_cnt_q;

  assign tx_ready_o   = ~tx_busy_q & cts_i;
  assign serial_out_o = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign rts_o        = local_ready_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else if (!tx_busy_q) begin
      if (data_in_valid_i) begin
        tx_shift_q <= {1'b1, data_in_i, 1'b0};
        tx_busy_q  <= 1'b1;
        tx_bit_q   <= '0;
        tx_cnt_q   <= '0;
      end
    end else if (tx_cnt_q != CNT_W'(CPB - 1)) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_q   <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      tx_bit_q   <= tx_bit_q + 1'b1;
      if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
    end
  end

  logic             rx_s1_q, rx_s2_q, rx_busy_q;
  logic [3:0]       rx_bit_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [7:0]       rx_shift_q;

  // Start edge arms a half-bit countdown so every later sample lands mid-bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q          <= 1'b1;
      rx_s2_q          <= 1'b1;
      rx_busy_q        <= 1'b0;
      rx_bit_q         <= '0;
      rx_cnt_q         <= '0;
      rx_shift_q       <= '0;
      data_out_o       <= '0;
      data_out_valid_o <= 1'b0;
    end else begin
      rx_s1_q          <= serial_in_i;
      rx_s2_q          <= rx_s1_q;
      data_out_valid_o <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= CNT_W'(CPB / 2);
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= CNT_W'(CPB - 1);
        rx_bit_q <= rx_bit_q + 1'b1;
        if (rx_bit_q == 4'd0) begin
          if (rx_s2_q) rx_busy_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q        <= 1'b0;
          data_out_o       <= rx_shift_q;
          data_out_valid_o <= rx_s2_q;
        end else begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_arbiter_controller_arb.sv
// rr_lock_arbiter: registered round-robin lock arbiter; a grant is held until its owner drops the request.
// Revision: 1.0
`default_nettype none

module rr_lock_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] lock_req_i,
  output logic [NUM_CH-1:0] lock_grant_o
);

  arb_state_e        state_q;
  logic [CH_W-1:0]   idx_q, ptr_q, idx_inc;
  logic [NUM_CH-1:0] grant_q;
  logic [MAX_CH-1:0] req_ext;
  arb_pick_t         pick_idle, pick_pass;

  assign req_ext      = MAX_CH'(lock_req_i);
  assign lock_grant_o = grant_q;

  always_comb begin
    idx_inc   = (idx_q == CH_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
    pick_idle = next_requester(req_ext, ptr_q, NUM_CH);
    // Scanning from idx+1 visits the releasing owner last.
    pick_pass = next_requester(req_ext, idx_inc, NUM_CH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_idle.found) begin
            state_q <= ARB_HELD;
            idx_q   <= pick_idle.idx;
            grant_q <= NUM_CH'(1) << pick_idle.idx;
          end
        end
        ARB_HELD: begin
          if (!req_ext[idx_q]) begin
            ptr_q <= idx_inc;
            if (pick_pass.found) begin
              idx_q   <= pick_pass.idx;
              grant_q <= NUM_CH'(1) << pick_pass.idx;
            end else begin
              state_q <= ARB_IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_arbiter_controller.sv
// uart_arbiter_controller: NUM_CH writers share one UART via a lock arbiter and TX FIFO; RX bytes land in a FWFT FIFO.
// Optional: UART_ARB_RX_FLOW_CTRL_EN drives uart local_ready from RX FIFO headroom. Revision: 1.0
`default_nettype none

module uart_arbiter_controller
  import uart_arb_pkg::*;
#(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_FREQ  = 125_000_000,
  parameter int NUM_CH      = 4,
  parameter int TX_DEPTH    = 256,
  parameter int RX_DEPTH    = 256,
  parameter int RX_HEADROOM = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             lock_req,
  output logic [NUM_CH-1:0]             lock_grant,
  input  logic [8*NUM_CH-1:0]           tx_data,
  input  logic [NUM_CH-1:0]             tx_valid,
  output logic [NUM_CH-1:0]             tx_ready,
  output byte_t                         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_count,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_count,
  output logic                          rx_overflow,
  input  logic                          serial_in,
  output logic                          serial_out,
  input  logic                          cts,
  output logic                          rts
);

  if (NUM_CH < 2 || NUM_CH > MAX_CH || RX_HEADROOM >= RX_DEPTH) begin : g_param_check
    $error("uart_arbiter_controller: illegal parameter combination");
  end

  logic  tx_full, tx_empty, tx_push, tx_pop, tx_pend_q, uart_tx_ready;
  byte_t tx_wdata, tx_head, tx_byte_q;
  logic  rx_full, rx_empty, uart_rx_valid, rx_overflow_q, local_ready;
  byte_t uart_rx_data;

  rr_lock_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clock        (clock),
    .reset        (reset),
    .lock_req_i   (lock_req),
    .lock_grant_o (lock_grant)
  );

  assign tx_ready = lock_grant & {NUM_CH{~tx_full}};

  always_comb begin
    tx_push  = 1'b0;
    tx_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lock_grant[i]) begin
        tx_push  = tx_valid[i] & tx_ready[i];
        tx_wdata = tx_data[8*i +: 8];
      end
    end
  end

  fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (tx_push),
    .wr_data_i (tx_wdata),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_head),
    .empty_o   (tx_empty),
    .full_o    (tx_full),
    .count_o   (tx_count)
  );

  // uart tx_ready stays high until it sees the staged byte, so block a second pop meanwhile.
  assign tx_pop = uart_tx_ready & ~tx_empty & ~tx_pend_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_pend_q     <= 1'b0;
      tx_byte_q     <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      tx_pend_q <= tx_pop;
      if (tx_pop) tx_byte_q <= tx_head;
      if (uart_rx_valid && rx_full && !rx_ready) rx_overflow_q <= 1'b1;
    end
  end

  fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (uart_rx_valid),
    .wr_data_i (uart_rx_data),
    .rd_en_i   (rx_ready),
    .rd_data_o (rx_data),
    .empty_o   (rx_empty),
    .full_o    (rx_full),
    .count_o   (rx_count)
  );

  assign rx_valid    = ~rx_empty;
  assign rx_overflow = rx_overflow_q;

`ifdef UART_ARB_RX_FLOW_CTRL_EN
  logic local_ready_q;
  always_ff @(posedge clock) begin
    if (reset) local_ready_q <= 1'b1;
    else       local_ready_q <= (RX_DEPTH - int'(rx_count)) > RX_HEADROOM;
  end
  assign local_ready = local_ready_q;
`else
  assign local_ready = 1'b1;
`endif

  uart #(.BAUD_RATE(BAUD_RATE), .CLOCK_FREQ(CLOCK_FREQ)) u_uart (
    .clock            (clock),
    .reset            (reset),
    .data_in_i        (tx_byte_q),
    .data_in_valid_i  (tx_pend_q),
    .tx_ready_o       (uart_tx_ready),
    .data_out_o       (uart_rx_data),
    .data_out_valid_o (uart_rx_valid),
    .local_ready_i    (local_ready),
    .cts_i            (cts),
    .rts_o            (rts),
    .serial_in_i      (serial_in),
    .serial_out_o     (serial_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_arbiter_controller.sv
// tb_uart_arbiter_controller: directed self-checking bench for the UART arbiter front end.
// Revision: 1.0
`default_nettype none

module tb_uart_arbiter_controller;

  localparam int NUM_CH   = 4;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;
  localparam int CPB      = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  lock_req = '0;
  logic [3:0]  lock_grant;
  logic [31:0] tx_data = '0;
  logic [3:0]  tx_valid = '0;
  logic [3:0]  tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [3:0]  tx_count;
  logic [3:0]  rx_count;
  logic        rx_overflow;
  logic        serial_in = 1'b1;
  logic        serial_out;
  logic        cts = 1'b1;
  logic        rts;

  int errors = 0;
  int checks = 0;

  uart_arbiter_controller #(
    .BAUD_RATE(1_000_000), .CLOCK_FREQ(8_000_000), .NUM_CH(NUM_CH),
    .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .RX_HEADROOM(2)
  ) dut (
    .clock(clock), .reset(reset), .lock_req(lock_req), .lock_grant(lock_grant),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count), .rx_overflow(rx_overflow),
    .serial_in(serial_in), .serial_out(serial_out), .cts(cts), .rts(rts)
  );

  always #5 clock = ~clock;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Decode one 8N1 frame from serial_out; ok=0 when no valid frame appears in time.
  task automatic uart_get(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    b  = '0;
    while (serial_out !== 1'b0 && n < 400) begin step(1); n++; end
    if (serial_out !== 1'b0) return;
    step(CPB / 2);
    if (serial_out !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin step(CPB); b[i] = serial_out; end
    step(CPB);
    ok = (serial_out === 1'b1);
  endtask

  task automatic send_serial(input logic [7:0] b);
    serial_in = 1'b0; step(CPB);
    for (int i = 0; i < 8; i++) begin serial_in = b[i]; step(CPB); end
    serial_in = 1'b1; step(CPB);
    step(4);
  endtask

  task automatic test_reset();
    int lows = 0;
    reset = 1'b1; step(3); reset = 1'b0;
    checks++; if (lock_grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", lock_grant); end
    checks++; if (tx_ready !== 4'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0000", tx_ready); end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: valid=%b data=%h want 0/00", rx_valid, rx_data); end
    checks++; if (tx_count !== 4'd0 || rx_count !== 4'd0) begin errors++; $display("FAIL reset_counts: tx=%0d rx=%0d want 0/0", tx_count, rx_count); end
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", rx_overflow); end
    repeat (1000) begin step(1); if (serial_out !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL idle_line: %0d low samples want 0", lows); end
  endtask

  task automatic test_arbiter();
    lock_req = 4'b1010; step(1);
    checks++; if (lock_grant !== 4'b0010) begin errors++; $display("FAIL arb_first: got %b want 0010", lock_grant); end
    checks++; if (tx_ready !== 4'b0010) begin errors++; $display("FAIL arb_tx_ready: got %b want 0010", tx_ready); end
    step(1);
    checks++; if (lock_grant !== 4'b0010) begin errors++; $display("FAIL arb_hold: got %b want 0010", lock_grant); end
    lock_req = 4'b1000; step(1);
    checks++; if (lock_grant !== 4'b1000) begin errors++; $display("FAIL arb_pass: got %b want 1000", lock_grant); end
    lock_req = 4'b0000; step(1);
    checks++; if (lock_grant !== 4'b0000) begin errors++; $display("FAIL arb_release: got %b want 0000", lock_grant); end
    lock_req = 4'b1111; step(1);
    checks++; if (lock_grant !== 4'b0001) begin errors++; $display("FAIL arb_ptr_zero: got %b want 0001", lock_grant); end
    lock_req = 4'b1110; step(1);
    checks++; if (lock_grant !== 4'b0010) begin errors++; $display("FAIL arb_pass_next: got %b want 0010", lock_grant); end
    lock_req = 4'b0000; step(1);
    lock_req = 4'b0011; step(1);
    checks++; if (lock_grant !== 4'b0001) begin errors++; $display("FAIL arb_rr_wrap: got %b want 0001", lock_grant); end
    lock_req = 4'b0000; step(2);
  endtask

  task automatic test_tx_basic();
    logic [7:0] b;
    bit         ok;
    int         n = 0;
    int         lows = 0;
    lock_req = 4'b0100;
    while (lock_grant !== 4'b0100 && n < 10) begin step(1); n++; end
    checks++; if (lock_grant !== 4'b0100) begin errors++; $display("FAIL tx_grant2: got %b want 0100", lock_grant); end
    tx_data[7:0] = 8'hEE; tx_valid[0] = 1'b1;
    tx_data[23:16] = 8'h55; tx_valid[2] = 1'b1; step(1);
    tx_data[23:16] = 8'hA3; step(1);
    tx_valid[2] = 1'b0;
    checks++; if (tx_count !== 4'd1) begin errors++; $display("FAIL tx_push_pop: count=%0d want 1", tx_count); end
    uart_get(b, ok);
    checks++; if (!ok || b !== 8'h55) begin errors++; $display("FAIL tx_byte0: got %h ok=%0d want 55", b, ok); end
    uart_get(b, ok);
    checks++; if (!ok || b !== 8'hA3) begin errors++; $display("FAIL tx_byte1: got %h ok=%0d want a3", b, ok); end
    repeat (200) begin step(1); if (serial_out !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL tx_no_extra: %0d low samples want 0", lows); end
    checks++; if (tx_count !== 4'd0) begin errors++; $display("FAIL tx_drained: count=%0d want 0", tx_count); end
    tx_valid = '0; lock_req = '0; step(2);
  endtask

  task automatic test_tx_fill();
    logic [7:0] b;
    bit         ok;
    int         n = 0;
    cts = 1'b0;
    lock_req = 4'b0010;
    while (lock_grant !== 4'b0010 && n < 10) begin step(1); n++; end
    tx_valid[1] = 1'b1;
    for (int k = 0; k <= TX_DEPTH; k++) begin tx_data[15:8] = 8'h10 + 8'(k); step(1); end
    tx_valid[1] = 1'b0;
    checks++; if (tx_count !== 4'd8) begin errors++; $display("FAIL tx_full_count: got %0d want 8", tx_count); end
    checks++; if (tx_ready !== 4'b0000) begin errors++; $display("FAIL tx_full_ready: got %b want 0000", tx_ready); end
    cts = 1'b1;
    for (int k = 0; k < TX_DEPTH; k++) begin
      uart_get(b, ok);
      checks++; if (!ok || b !== 8'h10 + 8'(k)) begin errors++; $display("FAIL tx_drain_%0d: got %h ok=%0d want %h", k, b, ok, 8'h10 + 8'(k)); end
    end
    step(20);
    checks++; if (tx_count !== 4'd0) begin errors++; $display("FAIL tx_fill_empty: count=%0d want 0", tx_count); end
    lock_req = '0; step(2);
  endtask

  task automatic test_rx_overflow();
    rx_ready = 1'b0;
    for (int k = 0; k < RX_DEPTH; k++) send_serial(8'hC0 + 8'(k));
    step(10);
    checks++; if (rx_count !== 4'd8 || rx_overflow !== 1'b0) begin errors++; $display("FAIL rx_full: count=%0d ovf=%b want 8/0", rx_count, rx_overflow); end
`ifndef UART_ARB_RX_FLOW_CTRL_EN
    checks++; if (rts !== 1'b1) begin errors++; $display("FAIL rts_tied: got %b want 1", rts); end
`endif
    send_serial(8'hC8);
    step(10);
    checks++; if (rx_count !== 4'd8) begin errors++; $display("FAIL rx_ovf_count: got %0d want 8", rx_count); end
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL rx_ovf_flag: got %b want 1", rx_overflow); end
    for (int k = 0; k < RX_DEPTH; k++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hC0 + 8'(k)) begin errors++; $display("FAIL rx_pop_%0d: valid=%b data=%h want 1/%h", k, rx_valid, rx_data, 8'hC0 + 8'(k)); end
      rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_empty_valid: got %b want 0", rx_valid); end
    rx_ready = 1'b1; step(2); rx_ready = 1'b0;
    checks++; if (rx_count !== 4'd0) begin errors++; $display("FAIL rx_empty_pop: count=%0d want 0", rx_count); end
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL rx_ovf_sticky: got %b want 1", rx_overflow); end
    reset = 1'b1; step(2); reset = 1'b0;
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rx_ovf_reset: got %b want 0", rx_overflow); end
  endtask

`ifdef UART_ARB_RX_FLOW_CTRL_EN
  task automatic test_flow_ctrl();
    rx_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_serial(8'h30 + 8'(k));
    step(4);
    checks++; if (rts !== 1'b1) begin errors++; $display("FAIL flow_free3: rts=%b want 1", rts); end
    send_serial(8'h35);
    step(4);
    checks++; if (rts !== 1'b0) begin errors++; $display("FAIL flow_free2: rts=%b want 0", rts); end
    rx_ready = 1'b1; step(1); rx_ready = 1'b0; step(2);
    checks++; if (rts !== 1'b1) begin errors++; $display("FAIL flow_restore: rts=%b want 1", rts); end
    reset = 1'b1; step(2); reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_arbiter();
    test_tx_basic();
    test_tx_fill();
    test_rx_overflow();
`ifdef UART_ARB_RX_FLOW_CTRL_EN
    test_flow_ctrl();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
